// File: rtl/sm4_pkg.sv
// sm4_pkg: shared SM4 key-schedule definitions.
//   FK0..FK3   - system parameters XORed into the master key on load
//   ks_state_e - key-expansion FSM states
//   ck_word()  - CK[i] round constant, byte j (MSB first) = ((4i+j)*7) mod 256
//   rotl()     - 32-bit rotate left
//   l_key()    - L' linear transform used by the key schedule
//   l_enc()    - L linear transform used by the round datapath
package sm4_pkg;

  localparam logic [31:0] FK0 = 32'hA3B1BAC6;
  localparam logic [31:0] FK1 = 32'h56AA3350;
  localparam logic [31:0] FK2 = 32'h677D9197;
  localparam logic [31:0] FK3 = 32'hB27022DC;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSub  = 2'd1,
    StMix  = 2'd2,
    StDone = 2'd3
  } ks_state_e;

  function automatic logic [31:0] ck_word(input logic [4:0] idx);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      // Truncation to 8 bits is the mod 256.
      w[8*(3-j) +: 8] = 8'(((4 * int'(idx)) + j) * 7);
    end
    return w;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] l_key(input logic [31:0] b);
    return b ^ rotl(b, 13) ^ rotl(b, 23);
  endfunction

  function automatic logic [31:0] l_enc(input logic [31:0] b);
    return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
  endfunction

endpackage

// File: rtl/key_expand_if.sv
// key_expand_if: request/result bundle of the SM4 key expander.
//   MK_i[127:0]     master key (MK0 in the top word)
//   MODE_i          0 = encrypt key order, 1 = reversed (decrypt) order
//   START_i         expansion request
//   BUSY_o          expansion in progress
//   DONE_o          one-cycle completion pulse
//   RK_VALID_o      a key set has been published since reset/zeroize
//   RK_o[1023:0]    round keys, round 0 in the top word (encrypt order)
// master drives the request side, slave is the key expander.
interface key_expand_if;
  logic [127:0]  MK_i;
  logic          MODE_i;
  logic          START_i;
  logic          BUSY_o;
  logic          DONE_o;
  logic          RK_VALID_o;
  logic [1023:0] RK_o;

  modport master (
    output MK_i, MODE_i, START_i,
    input  BUSY_o, DONE_o, RK_VALID_o, RK_o
  );

  modport slave (
    input  MK_i, MODE_i, START_i,
    output BUSY_o, DONE_o, RK_VALID_o, RK_o
  );
endinterface

// File: rtl/sbox_32b.sv
// sbox_32b: four parallel SM4 S-boxes with a registered output (1-cycle latency).
//   CLK_i        clock
//   X_i[31:0]    input word
//   Y_o[31:0]    S(X_i) from the previous cycle
module sbox_32b (
  input  logic        CLK_i,
  input  logic [31:0] X_i,
  output logic [31:0] Y_o
);

  localparam logic [2047:0] Sbox = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  logic [31:0] y_d, y_q;

  always_comb begin
    y_d = '0;
    for (int j = 0; j < 4; j++) begin
      y_d[8*j +: 8] = Sbox[8*(255 - int'(X_i[8*j +: 8])) +: 8];
    end
  end

  always_ff @(posedge CLK_i) begin
    y_q <= y_d;
  end

  assign Y_o = y_q;

endmodule

// File: rtl/key_expand.sv
// key_expand: SM4 key schedule. Expands a 128-bit master key into 32 round keys,
// one round every two cycles through a single registered 32-bit S-box, and
// publishes the full set on RK_o only at completion so the round datapath keeps
// using the previous keys while a new expansion runs.
//   CLK_i      clock
//   RST_N_i    asynchronous active-low reset
//   ZEROIZE_i  synchronous clear of all key state (only with SM4_KEYEXP_ZEROIZE_EN)
//   bus        key_expand_if.slave (MK_i, MODE_i, START_i, BUSY_o, DONE_o, RK_VALID_o, RK_o)
// Optional feature macro: SM4_KEYEXP_ZEROIZE_EN.
module key_expand
  import sm4_pkg::*;
(
  input logic CLK_i,
  input logic RST_N_i,
`ifdef SM4_KEYEXP_ZEROIZE_EN
  input logic ZEROIZE_i,
`endif
  key_expand_if.slave bus
);

  ks_state_e     state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [127:0]  k_q, k_d;        // sliding window K[i]..K[i+3], K[i] in the top word
  logic [1023:0] work_q, work_d;
  logic [1023:0] rk_q, rk_d;
  logic          mode_q, mode_d;
  logic          valid_q, valid_d;
  logic [31:0]   sbox_x, sbox_y, rk_new;
  logic [1023:0] final_keys, rev_keys;
  logic          zeroize;

`ifdef SM4_KEYEXP_ZEROIZE_EN
  assign zeroize = ZEROIZE_i;
`else
  assign zeroize = 1'b0;
`endif

  sbox_32b u_sbox (
    .CLK_i (CLK_i),
    .X_i   (sbox_x),
    .Y_o   (sbox_y)
  );

  // The S-box sees this in StSub; k_q is stable until the StMix edge, so the
  // registered result in StMix belongs to the same round.
  assign sbox_x = k_q[95:64] ^ k_q[63:32] ^ k_q[31:0] ^ ck_word(cnt_q);
  assign rk_new = k_q[127:96] ^ l_key(sbox_y);

  // Slot 31 of the working register is still zero when round 31 finishes.
  assign final_keys = work_q | {992'd0, rk_new};

  always_comb begin
    rev_keys = '0;
    for (int w = 0; w < 32; w++) begin
      rev_keys[32*w +: 32] = final_keys[32*(31-w) +: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    work_d  = work_q;
    rk_d    = rk_q;
    mode_d  = mode_q;
    valid_d = valid_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.START_i) begin
          k_d     = bus.MK_i ^ {FK0, FK1, FK2, FK3};
          cnt_d   = '0;
          work_d  = '0;
          mode_d  = bus.MODE_i;
          state_d = StSub;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StSub: state_d = StMix;
      StMix: begin
        k_d = {k_q[95:0], rk_new};
        work_d[32*(31 - int'(cnt_q)) +: 32] = rk_new;
        if (cnt_q == 5'd31) begin
          rk_d    = mode_q ? rev_keys : final_keys;
          valid_d = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d   = cnt_q + 5'd1;
          state_d = StSub;
        end
      end
      default: state_d = StIdle;
    endcase

    if (zeroize) begin
      state_d = StIdle;
      cnt_d   = '0;
      k_d     = '0;
      work_d  = '0;
      rk_d    = '0;
      mode_d  = 1'b0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      k_q     <= '0;
      work_q  <= '0;
      rk_q    <= '0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      work_q  <= work_d;
      rk_q    <= rk_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
    end
  end

  assign bus.BUSY_o     = (state_q == StSub) || (state_q == StMix);
  assign bus.DONE_o     = (state_q == StDone);
  assign bus.RK_VALID_o = valid_q;
  assign bus.RK_o       = rk_q;

endmodule

// File: tb/tb_key_expand.sv
// tb_key_expand: self-checking bench for key_expand. A behavioural model computes
// the round keys straight from the SM4 key-schedule equations and tracks the
// 64-edge completion timing; a compare process checks every output each cycle.
// Literal SM4 reference values pin both the model and the DUT.
module tb_key_expand;

  localparam logic [127:0] MkStd = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] CtStd = 128'h681EDF34D206965E86B3E94F536E4246;

  localparam logic [2047:0] SboxTbl = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  logic clk = 1'b0;
  logic rst_n;
  logic zeroize;
  logic chk_en = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  key_expand_if bus ();

  key_expand dut (
    .CLK_i     (clk),
    .RST_N_i   (rst_n),
`ifdef SM4_KEYEXP_ZEROIZE_EN
    .ZEROIZE_i (zeroize),
`endif
    .bus       (bus)
  );

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = SboxTbl[2047 - 8*int'(a[8*j +: 8]) -: 8];
    return r;
  endfunction

  function automatic logic [1023:0] model_keys(input logic [127:0] mk, input logic rev);
    logic [31:0]   k [36];
    logic [31:0]   fk [4];
    logic [31:0]   ck, b;
    logic [1023:0] out;
    int            slot;
    fk = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
    out = '0;
    for (int i = 0; i < 4; i++) k[i] = mk[127 - 32*i -: 32] ^ fk[i];
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31 - 8*j -: 8] = 8'(((4*i + j) * 7) % 256);
      b = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      k[i+4] = k[i] ^ b ^ rol(b, 13) ^ rol(b, 23);
      slot = rev ? 31 - i : i;
      out[1023 - 32*slot -: 32] = k[i+4];
    end
    return out;
  endfunction

  function automatic logic [127:0] sm4_enc(input logic [127:0] pt, input logic [1023:0] rk);
    logic [31:0] x [36];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) x[i] = pt[127 - 32*i -: 32];
    for (int i = 0; i < 32; i++) begin
      t = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ rk[1023 - 32*i -: 32]);
      x[i+4] = x[i] ^ t ^ rol(t, 2) ^ rol(t, 10) ^ rol(t, 18) ^ rol(t, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    int w;
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      w = 31;
      for (int i = 0; i < 32; i++) begin
        if (act[1023 - 32*i -: 32] !== exp[1023 - 32*i -: 32]) begin
          w = i;
          break;
        end
      end
      $display("FAIL %s @%0t: word %0d is %h, required %h", name, $time, w,
               act[1023 - 32*w -: 32], exp[1023 - 32*w -: 32]);
    end
  endtask

  // Reference model: edges left until completion (0 = idle).
  int            m_left;
  logic          m_done, m_valid, m_mode;
  logic [1023:0] m_rk;
  logic [127:0]  m_mk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || zeroize) begin
      m_left <= 0; m_done <= 1'b0; m_valid <= 1'b0; m_rk <= '0; m_mk <= '0; m_mode <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 1) begin
        m_left  <= 0;
        m_done  <= 1'b1;
        m_valid <= 1'b1;
        m_rk    <= model_keys(m_mk, m_mode);
      end else if (m_left > 1) begin
        m_left <= m_left - 1;
      end else if (bus.START_i) begin
        m_left <= 64;
        m_mk   <= bus.MK_i;
        m_mode <= bus.MODE_i;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 1024'(bus.BUSY_o), 1024'(m_left > 0));
      check("done", 1024'(bus.DONE_o), 1024'(m_done));
      check("rk_valid", 1024'(bus.RK_VALID_o), 1024'(m_valid));
      check("rk", bus.RK_o, m_rk);
    end
  end

  task automatic wait_done(input string name);
    int n = 0;
    while (bus.DONE_o !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (bus.DONE_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: DONE_o not seen within 80 cycles", name);
    end
  endtask

  task automatic pulse_start(input logic [127:0] mk, input logic mode);
    bus.MK_i = mk; bus.MODE_i = mode; bus.START_i = 1'b1;
    @(negedge clk);
    bus.START_i = 1'b0;
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_busy"}, 1024'(bus.BUSY_o), 1024'(0));
    check({name, "_done"}, 1024'(bus.DONE_o), 1024'(0));
    check({name, "_valid"}, 1024'(bus.RK_VALID_o), 1024'(0));
    check({name, "_rk"}, bus.RK_o, 1024'(0));
  endtask

  initial begin
    logic [1023:0] mref;
    rst_n = 1'b0; zeroize = 1'b0;
    bus.MK_i = '0; bus.MODE_i = 1'b0; bus.START_i = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check_zero_outputs("reset");

    // Pin the model against the published SM4 key schedule.
    mref = model_keys(MkStd, 1'b0);
    check("model_rk0", 1024'(mref[1023:992]), 1024'(32'hF12186F9));
    check("model_rk31", 1024'(mref[31:0]), 1024'(32'h9124A012));
    check("model_enc", 1024'(sm4_enc(MkStd, mref)), 1024'(CtStd));

    rst_n = 1'b1;
    @(negedge clk);

    // Run A: standard key, encrypt order; a second START at cycle 20 must be ignored.
    pulse_start(MkStd, 1'b0);
    repeat (18) @(negedge clk);
    pulse_start(~MkStd, 1'b1);
    wait_done("run_a");
    check("a_rk0", 1024'(bus.RK_o[1023:992]), 1024'(32'hF12186F9));
    check("a_rk1", 1024'(bus.RK_o[991:960]), 1024'(32'h41662B61));
    check("a_rk31", 1024'(bus.RK_o[31:0]), 1024'(32'h9124A012));
    check("a_cipher", 1024'(sm4_enc(MkStd, bus.RK_o)), 1024'(CtStd));

    // Run B: decrypt order, requested in the DONE_o cycle (back-to-back).
    pulse_start(MkStd, 1'b1);
    check("b_busy", 1024'(bus.BUSY_o), 1024'(1));
    check("b_rk_hold", 1024'(bus.RK_o[1023:992]), 1024'(32'hF12186F9));
    wait_done("run_b");
    check("b_top", 1024'(bus.RK_o[1023:992]), 1024'(32'h9124A012));
    check("b_bottom", 1024'(bus.RK_o[31:0]), 1024'(32'hF12186F9));
    @(negedge clk);

    // Run C: random key, aborted by reset at cycle 30.
    pulse_start({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    repeat (28) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    wait_done("run_c");
    check("c_valid", 1024'(bus.RK_VALID_o), 1024'(1));
    @(negedge clk);

`ifdef SM4_KEYEXP_ZEROIZE_EN
    // Zeroize at cycle 10 wins over a simultaneous START.
    pulse_start(MkStd, 1'b0);
    repeat (8) @(negedge clk);
    zeroize = 1'b1; bus.START_i = 1'b1;
    @(negedge clk);
    zeroize = 1'b0; bus.START_i = 1'b0;
    check_zero_outputs("zeroize");
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_expand.md
KEY_EXPAND -- requirements
Module: key_expand

Interface
REQ-001 Parameters: none; all widths fixed by SM4.
REQ-002 CLK_i  input  1  single clock; all state on rising edge.
REQ-003 RST_N_i  input  1  reset, asynchronous assert, active-low.
REQ-004 MK_i  input  128  master key; word MK0 = MK_i[127:96], MK3 = MK_i[31:0].
REQ-005 MODE_i  input  1  0 = encrypt key order, 1 = decrypt (reversed) order; sampled with START_i.
REQ-006 START_i  input  1  request expansion; accepted only when BUSY_o = 0.
REQ-007 BUSY_o  output  1  high from the edge accepting START_i until the completion edge.
REQ-008 DONE_o  output  1  one-cycle pulse on completion.
REQ-009 RK_VALID_o  output  1  high once any expansion has completed; stays high until reset.
REQ-010 RK_o  output  1024  round-key bus for the SM4 round datapath; round r key at RK_o[32*(32-r)-1:32*(31-r)].

Function
REQ-011 Load: on the edge accepting START_i, K0..K3 = MKi ^ FKi (FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC), round counter = 0, and MK_i/MODE_i are captured.
REQ-012 Round i: a = K[i+1]^K[i+2]^K[i+3]^CK[i]; CK[i] byte j (MSB first) = ((4i+j)*7) mod 256.
REQ-013 Round i: rk_i = K[i+4] = K[i] ^ L'(S(a)); L'(B) = B ^ (B<<<13) ^ (B<<<23).
REQ-014 S() uses one registered 32-bit S-box with 1-cycle latency, so each round takes 2 cycles.
REQ-015 FSM states: IDLE -> SUB (present a to S-box) -> MIX (combine, store rk_i, shift K window) -> SUB while round < 31, else DONE-> IDLE.
REQ-016 Latency: DONE_o pulses and RK_o/RK_VALID_o update on the 64th rising edge after the edge accepting START_i.
REQ-017 Keys accumulate in a 1024-bit working register; RK_o is a separate shadow register written only at completion.
REQ-018 RK_o and RK_VALID_o hold their previous values for the whole expansion, so the downstream datapath keeps running on the old keys.
REQ-019 Completion with captured MODE=0: rk0 goes to RK_o[1023:992] and rk31 to RK_o[31:0].
REQ-020 Completion with captured MODE=1: the word order is reversed, so rk31 goes to RK_o[1023:992] and rk0 to RK_o[31:0].
REQ-021 START_i while BUSY_o = 1 is ignored; changes on MK_i/MODE_i during expansion have no effect.
REQ-022 START_i in the completion cycle is ignored; START_i in the cycle after completion is accepted, giving back-to-back operation.
REQ-023 Round counter is 5 bits and never wraps within an operation.

Reset
REQ-024 RST_N_i low asynchronously forces: FSM = IDLE; counter, K window, working and shadow registers = 0; BUSY_o = DONE_o = RK_VALID_o = 0.
REQ-025 Reset mid-expansion aborts it; no partial keys ever reach RK_o.

Configuration
REQ-026 Macro SM4_KEYEXP_ZEROIZE_EN: when defined, adds input ZEROIZE_i (1 bit).
REQ-027 With the macro defined, ZEROIZE_i high clears all key state, RK_o and RK_VALID_o on the next edge, aborts any expansion and overrides a simultaneous START_i.
REQ-028 Without the macro, the port does not exist and keys are cleared only by reset.

Structure
REQ-029 Shared package sm4_pkg holds: FK constants, CK derivation function, L' and L rotation functions, FSM state typedef.
REQ-030 The only sub-module is the existing sbox_32b (CLK_i, X_i, Y_o), instantiated once.

Verification
REQ-031 MK = 0123456789ABCDEFFEDCBA9876543210, MODE = 0, START -> after 64 edges DONE_o pulses; RK_o[1023:992] = F12186F9, [991:960] = 41662B61, [31:0] = 9124A012.
REQ-032 Same MK with MODE = 1 -> RK_o[1023:992] = 9124A012, RK_o[31:0] = F12186F9.
REQ-033 Feed REQ-031 keys to the round datapath with plaintext 0123456789ABCDEFFEDCBA9876543210 -> ciphertext 681EDF34D206965E86B3E94F536E4246.
REQ-034 Second START with a new MK at cycle 20 of a run -> ignored; RK_o is unchanged until the first run completes and then holds the first-run keys.
REQ-035 RST_N_i low at cycle 30 -> all outputs 0 immediately; a subsequent START produces correct keys.
REQ-036 ZEROIZE_i (macro on) pulsed at cycle 10 with START_i high -> RK_o = 0, RK_VALID_o = 0, BUSY_o = 0 next cycle.
